// File: rtl/fp_wire_pkg.sv
// Shared types for the fp_unit issue arbiter: command bundle, FSM states, busy-counter helper.
package fp_wire;

  localparam int unsigned FP_DATA_W  = 64;
  localparam int unsigned FP_FLAGS_W = 5;
  localparam int unsigned WAIT_CNT_W = 16;

  typedef struct packed {
    logic [FP_DATA_W-1:0] data1;
    logic [FP_DATA_W-1:0] data2;
    logic [FP_DATA_W-1:0] data3;
    logic [1:0]           fmt;
    logic [2:0]           rm;
    logic [9:0]           opcode;
    logic [1:0]           fcvt_op;
  } fp_arb_cmd_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fp_arb_state_e;

  function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fp_arb_select.sv
// Combinational grant picker: one-hot grant plus index from the request vector.
// FP_ARB_ROUND_ROBIN_EN adds a start pointer; without it the lowest index wins.
module fp_arb_select
  import fp_wire::*;
#(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
`ifdef FP_ARB_ROUND_ROBIN_EN
  input  logic [IDW-1:0]  i_ptr,
`endif
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic w_found;

  always_comb begin
    w_found = 1'b0;
    o_gnt   = '0;
    o_idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      int c;
`ifdef FP_ARB_ROUND_ROBIN_EN
      // Scan upward from the pointer, wrapping past the top requester.
      c = (int'(i_ptr) + off) % NREQ;
`else
      c = off;
`endif
      if (!w_found && i_req[c]) begin
        w_found  = 1'b1;
        o_gnt[c] = 1'b1;
        o_idx    = IDW'(c);
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/fp_issue_arbiter.sv
// Shares one fp_unit among NREQ requesters, one op in flight (grant T, enable T+1, rsp >= T+3).
// Responses stall on rsp_ready; FP_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module fp_issue_arbiter
  import fp_wire::*;
#(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  fp_arb_cmd_type [NREQ-1:0] req_cmd,
  output logic                      fpu_enable,
  output fp_arb_cmd_type            fpu_cmd,
  input  logic                      fpu_ready,
  input  logic [FP_DATA_W-1:0]      fpu_result,
  input  logic [FP_FLAGS_W-1:0]     fpu_flags,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [FP_DATA_W-1:0]      rsp_result,
  output logic [FP_FLAGS_W-1:0]     rsp_flags
);

  fp_arb_state_e         r_state;
  fp_arb_state_e         w_state_nxt;
  logic [NREQ-1:0]       w_gnt;
  logic [IDW-1:0]        w_idx;
  logic                  w_any;
  logic                  w_grant_en;

  fp_arb_cmd_type        r_cmd;
  logic [IDW-1:0]        r_owner;
  logic [FP_DATA_W-1:0]  r_result;
  logic [FP_FLAGS_W-1:0] r_flags;
  logic [WAIT_CNT_W-1:0] wait_cnt;
`ifdef FP_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0]        r_ptr;
`endif

  fp_arb_select #(.NREQ(NREQ)) u_select (
    .i_req (req_valid),
`ifdef FP_ARB_ROUND_ROBIN_EN
    .i_ptr (r_ptr),
`endif
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // reset gates the grant so req_ready reads 0 while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    req_ready   = '0;
    fpu_enable  = 1'b0;
    rsp_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (reset && w_any) begin
          w_grant_en  = 1'b1;
          req_ready   = w_gnt;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        fpu_enable  = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (fpu_ready) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cmd    <= '0;
      r_owner  <= '0;
      r_result <= '0;
      r_flags  <= '0;
      wait_cnt <= '0;
    end else begin
      if (w_grant_en) begin
        r_cmd    <= req_cmd[w_idx];
        r_owner  <= w_idx;
        wait_cnt <= '0;
      end
      if (r_state == WAIT) begin
        wait_cnt <= sat_inc(wait_cnt);
        if (fpu_ready) begin
          r_result <= fpu_result;
          r_flags  <= fpu_flags;
        end
      end
    end
  end

`ifdef FP_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (w_grant_en) begin
      r_ptr <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end
`endif

  assign fpu_cmd    = r_cmd;
  assign rsp_id     = r_owner;
  assign rsp_result = r_result;
  assign rsp_flags  = r_flags;

endmodule

// File: tb/tb_fp_issue_arbiter.sv
// Directed bench for fp_issue_arbiter: scoreboard of expected responses, fp_unit latency model.
module tb_fp_issue_arbiter;
  import fp_wire::*;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  fp_arb_cmd_type [1:0]  req_cmd;
  logic                  fpu_enable;
  fp_arb_cmd_type        fpu_cmd;
  logic                  fpu_ready;
  logic [63:0]           fpu_result;
  logic [4:0]            fpu_flags;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [0:0]            rsp_id;
  logic [63:0]           rsp_result;
  logic [4:0]            rsp_flags;

  logic        model_ready = 1'b0;
  logic        model_busy  = 1'b0;
  logic [63:0] model_res   = '0;
  logic [4:0]  model_flags = '0;
  logic        spur_ready  = 1'b0;
  logic [63:0] spur_res    = '0;

  assign fpu_ready  = model_ready | spur_ready;
  assign fpu_result = spur_ready ? spur_res : model_res;
  assign fpu_flags  = spur_ready ? 5'h1F : model_flags;

  typedef struct { int id; logic [63:0] res; logic [4:0] flags; } exp_t;
  typedef struct { int lat; logic [63:0] res; logic [4:0] flags; } fop_t;
  exp_t exp_q[$];
  fop_t fpu_q[$];

  int checks = 0;
  int errors = 0;
  int enable_cnt = 0;
  int exp_order[4];

  fp_arb_cmd_type cmd_add, cmd_div, cmd_a, cmd_b;

  fp_issue_arbiter #(.NREQ(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .fpu_enable(fpu_enable), .fpu_cmd(fpu_cmd),
    .fpu_ready(fpu_ready), .fpu_result(fpu_result), .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chkcmd(input string name, input fp_arb_cmd_type act, input fp_arb_cmd_type exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Returns at the negedge of the grant cycle; idx = -1 on timeout.
  task automatic wait_grant(output int idx);
    idx = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (req_ready != 2'b00) begin
        idx = req_ready[0] ? 0 : 1;
        break;
      end
    end
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no req_ready in 100 cycles, want a grant");
    end
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || model_busy) && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("drain_outstanding", 64'(exp_q.size()), 0);
  endtask

  // fp_unit model: pops one latency/result per enable strobe.
  initial begin
    forever begin
      fop_t op;
      @(negedge clock);
      if (fpu_enable) begin
        if (fpu_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_enable: got fpu_enable with no queued op, want none");
        end else begin
          op = fpu_q.pop_front();
          model_busy = 1'b1;
          repeat (op.lat) @(posedge clock);
          #1;
          model_ready = 1'b1;
          model_res   = op.res;
          model_flags = op.flags;
          @(posedge clock);
          #1;
          model_ready = 1'b0;
          model_busy  = 1'b0;
        end
      end
    end
  end

  // Response monitor.
  always @(negedge clock) begin
    if (fpu_enable) enable_cnt++;
    if (reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d result 0x%0h, want no response", rsp_id, rsp_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_flags", 64'(rsp_flags), 64'(e.flags));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, en0, cyc;
    logic bad_rdy, stable, saw_rsp, saw_en;

    cmd_add = '{data1: 64'h3F800000, data2: 64'h3F800000, data3: 64'h0,
                fmt: 2'd0, rm: 3'd0, opcode: 10'h001, fcvt_op: 2'd0};
    cmd_div = '{data1: 64'h3F800000, data2: 64'h40000000, data3: 64'h0,
                fmt: 2'd0, rm: 3'd1, opcode: 10'h008, fcvt_op: 2'd0};
    cmd_a   = '{data1: 64'hAAAA, data2: 64'h1111, data3: 64'h5,
                fmt: 2'd1, rm: 3'd2, opcode: 10'h004, fcvt_op: 2'd1};
    cmd_b   = '{data1: 64'hBBBB, data2: 64'h2222, data3: 64'h6,
                fmt: 2'd0, rm: 3'd3, opcode: 10'h002, fcvt_op: 2'd2};
`ifdef FP_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    req_valid = 2'b00;
    req_cmd   = '0;
    rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_req_ready", 64'(req_ready), 0);
    chk("reset_fpu_enable", 64'(fpu_enable), 0);
    chkcmd("reset_fpu_cmd", fpu_cmd, '0);
    chk("reset_rsp_valid", 64'(rsp_valid), 0);
    chk("reset_rsp_id", 64'(rsp_id), 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_rsp_flags", 64'(rsp_flags), 0);
    chk("reset_wait_cnt", 64'(dut.wait_cnt), 0);
    tick();
    reset = 1'b1;

    // Single request, minimum latency: 1.0 + 1.0 = 2.0
    tick();
    fpu_q.push_back('{1, 64'h40000000, 5'h0});
    exp_q.push_back('{0, 64'h40000000, 5'h0});
    req_cmd[0] = cmd_add;
    req_valid  = 2'b01;
    wait_grant(idx);
    chk("t0_req_ready", 64'(req_ready), 64'h1);
    chk("t0_fpu_enable", 64'(fpu_enable), 0);
    tick();
    req_valid = 2'b00;
    @(negedge clock);
    chk("t1_fpu_enable", 64'(fpu_enable), 1);
    chkcmd("t1_fpu_cmd", fpu_cmd, cmd_add);
    @(negedge clock);
    chk("t2_fpu_enable", 64'(fpu_enable), 0);
    chk("t2_rsp_valid", 64'(rsp_valid), 0);
    @(negedge clock);
    chk("t3_rsp_valid", 64'(rsp_valid), 1);
    chk("t3_wait_cnt", 64'(dut.wait_cnt), 1);
    wait_drain();

    // Contention: both requesters held for four ops, pointer starts from reset
    @(negedge clock) reset = 1'b0;
    @(negedge clock) reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fpu_q.push_back('{1, 64'h1000 + 64'(k), 5'(k)});
      exp_q.push_back('{exp_order[k], 64'h1000 + 64'(k), 5'(k)});
    end
    req_cmd[0] = cmd_a;
    req_cmd[1] = cmd_b;
    tick();
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_grant(idx);
      chk("cont_grant_idx", 64'(idx), 64'(exp_order[k]));
      @(negedge clock);
      chkcmd("cont_fpu_cmd", fpu_cmd, (exp_order[k] == 1) ? cmd_b : cmd_a);
    end
    tick();
    req_valid = 2'b00;
    wait_drain();

    // Long FDIV op with a second requester waiting behind it
    fpu_q.push_back('{30, 64'h3F000000, 5'h0});
    exp_q.push_back('{0, 64'h3F000000, 5'h0});
    fpu_q.push_back('{1, 64'h2222, 5'h02});
    exp_q.push_back('{1, 64'h2222, 5'h02});
    req_cmd[0] = cmd_div;
    tick();
    req_valid = 2'b01;
    wait_grant(idx);
    chk("long_grant_idx", 64'(idx), 0);
    en0 = enable_cnt;
    tick();
    req_valid = 2'b10;
    bad_rdy = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin
      @(negedge clock);
      if (!rsp_valid && req_ready != 2'b00) bad_rdy = 1'b1;
      cyc++;
    end
    chk("long_rsp_valid", 64'(rsp_valid), 1);
    chk("long_enable_count", 64'(enable_cnt - en0), 1);
    chk("long_req_ready_low", 64'(bad_rdy), 0);
    chk("long_wait_cnt", 64'(dut.wait_cnt), 30);
    wait_grant(idx);
    chk("long_pending_grant", 64'(idx), 1);
    tick();
    req_valid = 2'b00;
    wait_drain();

    // Response backpressure for five cycles, req 1 pending
    rsp_ready = 1'b0;
    fpu_q.push_back('{1, 64'h0123456789ABCDEF, 5'h04});
    exp_q.push_back('{0, 64'h0123456789ABCDEF, 5'h04});
    fpu_q.push_back('{1, 64'h5555, 5'h08});
    exp_q.push_back('{1, 64'h5555, 5'h08});
    tick();
    req_cmd[0] = cmd_a;
    req_valid  = 2'b01;
    wait_grant(idx);
    chk("bp_grant_idx", 64'(idx), 0);
    tick();
    req_valid = 2'b10;
    wait_rsp();
    chk("bp_rsp_valid", 64'(rsp_valid), 1);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(rsp_valid === 1'b1 && rsp_id === 1'b0 &&
            rsp_result === 64'h0123456789ABCDEF && req_ready === 2'b00)) stable = 1'b0;
      if (i < 4) @(negedge clock);
    end
    chk("bp_held_stable", 64'(stable), 1);
    chk("bp_result_held", rsp_result, 64'h0123456789ABCDEF);
    tick();
    rsp_ready = 1'b1;
    @(negedge clock);
    chk("bp_no_grant_in_handshake", 64'(req_ready), 0);
    @(negedge clock);
    chk("bp_grant_after_handshake", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    wait_drain();

    // Spurious fpu_ready in IDLE, ISSUE and RESP
    tick();
    spur_res   = 64'hDEADBEEF;
    spur_ready = 1'b1;
    tick();
    spur_ready = 1'b0;
    @(negedge clock);
    chk("spur_idle_rsp_valid", 64'(rsp_valid), 0);
    chk("spur_idle_enable", 64'(fpu_enable), 0);
    chk("spur_idle_result", rsp_result, 64'h5555);
    tick();
    rsp_ready = 1'b0;
    fpu_q.push_back('{3, 64'h7777, 5'h10});
    exp_q.push_back('{1, 64'h7777, 5'h10});
    req_cmd[1] = cmd_b;
    req_valid  = 2'b10;
    wait_grant(idx);
    tick();
    req_valid  = 2'b00;
    spur_ready = 1'b1;
    tick();
    spur_ready = 1'b0;
    @(negedge clock);
    chk("spur_issue_rsp_valid", 64'(rsp_valid), 0);
    wait_rsp();
    chk("spur_resp_valid", 64'(rsp_valid), 1);
    tick();
    spur_res   = 64'h0BAD;
    spur_ready = 1'b1;
    tick();
    spur_ready = 1'b0;
    @(negedge clock);
    chk("spur_resp_result", rsp_result, 64'h7777);
    chk("spur_resp_flags", 64'(rsp_flags), 64'h10);
    tick();
    rsp_ready = 1'b1;
    wait_drain();

    // Reset during WAIT; the late fpu_ready must be ignored
    fpu_q.push_back('{20, 64'h9999, 5'h0});
    tick();
    req_cmd[0] = cmd_div;
    req_valid  = 2'b01;
    wait_grant(idx);
    tick();
    req_valid = 2'b00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_fpu_enable", 64'(fpu_enable), 0);
    chkcmd("rst_fpu_cmd", fpu_cmd, '0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_rsp_id", 64'(rsp_id), 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_flags", 64'(rsp_flags), 0);
    chk("rst_wait_cnt", 64'(dut.wait_cnt), 0);
    @(negedge clock) reset = 1'b1;
    saw_rsp = 1'b0;
    saw_en  = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (rsp_valid) saw_rsp = 1'b1;
      if (fpu_enable) saw_en = 1'b1;
    end
    chk("rst_no_rsp_valid", 64'(saw_rsp), 0);
    chk("rst_no_enable", 64'(saw_en), 0);
    chk("rst_model_done", 64'(model_busy), 0);
    chk("final_exp_q_empty", 64'(exp_q.size()), 0);
    chk("final_fpu_q_empty", 64'(fpu_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
